// File: rtl/multu_hilo_pkg.sv
// Shared definitions for the ALU control block and the HI/LO multiplier.
package multu_hilo_pkg;

  // Function/control codes driven by ALU control
  localparam logic [5:0] FN_AND       = 6'b100100;
  localparam logic [5:0] FN_OR        = 6'b100101;
  localparam logic [5:0] FN_ADD       = 6'b100000;
  localparam logic [5:0] FN_SUB       = 6'b100010;
  localparam logic [5:0] FN_SLT       = 6'b101010;
  localparam logic [5:0] FN_SRL       = 6'b000010;
  localparam logic [5:0] FN_MULT      = 6'b011001;
  localparam logic [5:0] FN_MFHI      = 6'b010000;
  localparam logic [5:0] FN_MFLO      = 6'b010010;
  localparam logic [5:0] FN_OPEN_HILO = 6'b111111;

  // Multiplier sequencing states (explicit encodings kept stable for legacy tools)
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } mul_state_e;

  // True for the two codes that keep a multiply alive (MULT or OPEN)
  function automatic logic is_mul_ctl(input logic [5:0] code);
    return (code == FN_MULT) || (code == FN_OPEN_HILO);
  endfunction

endpackage

// File: rtl/multu_hilo_hilo_reg.sv
// HI/LO result storage with write enable, synchronous clear and MFHI/MFLO read mux.
module multu_hilo_hilo_reg
  import multu_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [5:0]       sel,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Next HI/LO: load both halves together on a commit
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (we) begin
      hi_d = hi_in;
      lo_d = lo_in;
    end
  end

  // HI/LO flops, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Read mux sees the registered value, so a same-cycle commit returns the old data
  always_comb begin
    rd_data = '0;
    if (sel == FN_MFHI) rd_data = hi_q;
    else if (sel == FN_MFLO) rd_data = lo_q;
  end

endmodule

// File: rtl/multu_hilo.sv
// Sequential unsigned shift-add multiplier feeding the HI/LO registers.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting for MULT (ignored while block is set after a commit)
//   RUN     | one shift-add iteration per cycle, WIDTH iterations in total
//   WAIT    | product ready, waiting for OPEN (or a pending one) to commit
module multu_hilo
  import multu_hilo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
);

  mul_state_e         state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pending_q, pending_d;
  logic               block_q, block_d;
  logic               done_q, done_d;
  logic               commit;
  logic               other;

  // Sequencing and shift-add datapath
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    block_d   = block_q;
    commit    = 1'b0;
    other     = !is_mul_ctl(Signal);

    // Any unrelated instruction re-arms the multiplier
    if (other) block_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if ((Signal == FN_MULT) && !block_q) begin
          mcand_d   = {{WIDTH{1'b0}}, dataA};
          mplier_d  = dataB;
          product_d = '0;
          cnt_d     = '0;
          pending_d = 1'b0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (other) begin
          pending_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          if (mplier_q[0]) product_d = product_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (Signal == FN_OPEN_HILO) pending_d = 1'b1;
          // An OPEN seen on the last iteration still waits one cycle in WAIT
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (pending_q || (Signal == FN_OPEN_HILO)) begin
          commit    = 1'b1;
          block_d   = 1'b1;
          pending_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (other) begin
          pending_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    done_d = commit;
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      block_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      block_q   <= block_d;
      done_q    <= done_d;
    end
  end

  multu_hilo_hilo_reg #(
    .WIDTH (WIDTH)
  ) u_hilo (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (commit),
    .hi_in   (product_q[2*WIDTH-1:WIDTH]),
    .lo_in   (product_q[WIDTH-1:0]),
    .sel     (Signal),
    .rd_data (dataOut)
  );

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_multu_hilo.sv
// Directed bench for multu_hilo: full runs, early OPEN, abort, reset in WAIT.
module tb_multu_hilo;
  import multu_hilo_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [5:0]  Signal;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;

  int n_checks;
  int n_errors;
  int done_cnt;
  int done_base;

  multu_hilo #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Signal  (Signal),
    .dataA   (dataA),
    .dataB   (dataB),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses as seen by the clock edge
  always @(posedge clk) begin
    if (!rst_n) done_cnt <= done_cnt;
    else if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    Signal = FN_MFHI;
    #1 check({tag, " HI"}, 64'(dataOut), 64'(exp_hi));
    Signal = FN_MFLO;
    #1 check({tag, " LO"}, 64'(dataOut), 64'(exp_lo));
  endtask

  // Issue MULT on the next edge, end at the first negedge inside RUN
  task automatic do_start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Signal = FN_MULT;
    dataA  = a;
    dataB  = b;
    @(negedge clk);
    dataA = $urandom;
    dataB = $urandom;
  endtask

  // Complete run: 32 iterations in MULT, OPEN once in WAIT, then read back
  task automatic full_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    done_base = done_cnt;
    do_start(a, b);
    check({tag, " busy run"}, 64'(busy), 64'd1);
    repeat (32) @(negedge clk);
    check({tag, " busy wait"}, 64'(busy), 64'd1);
    check({tag, " no early done"}, 64'(done_cnt - done_base), 64'd0);
    Signal = FN_OPEN_HILO;
    @(negedge clk);
    check({tag, " done pulse"}, 64'(done), 64'd1);
    check({tag, " busy idle"}, 64'(busy), 64'd0);
    read_hilo(tag, exp_hi, exp_lo);
    @(negedge clk);
    check({tag, " done low"}, 64'(done), 64'd0);
    check({tag, " done count"}, 64'(done_cnt - done_base), 64'd1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    done_cnt = 0;
    rst_n    = 1'b0;
    Signal   = FN_AND;
    dataA    = '0;
    dataB    = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: reset state
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    read_hilo("rst", 32'h0, 32'h0);

    // 2, 3: full runs with OPEN in WAIT
    full_run("7x6", 32'h0000_0007, 32'h0000_0006, 32'h0, 32'h0000_002A);
    full_run("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

    // 4: OPEN during RUN cycle 31, then MULT held
    done_base = done_cnt;
    do_start(32'h1234_5678, 32'h0000_0010);
    repeat (30) @(negedge clk);
    Signal = FN_OPEN_HILO;
    @(negedge clk);
    Signal = FN_MULT;
    check("early busy c32", 64'(busy), 64'd1);
    @(negedge clk);
    check("early busy wait", 64'(busy), 64'd1);
    check("early no done yet", 64'(done_cnt - done_base), 64'd0);
    @(negedge clk);
    check("early done pulse", 64'(done), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("early block", 64'(busy), 64'd0);
    end
    check("early done count", 64'(done_cnt - done_base), 64'd1);
    read_hilo("early", 32'h0000_0001, 32'h2345_6780);
    Signal = FN_ADD;
    #1 check("other code reads 0", 64'(dataOut), 64'd0);

    // 5: abort with ADD at RUN cycle 10
    done_base = done_cnt;
    do_start(32'd3, 32'd5);
    repeat (9) @(negedge clk);
    check("abort busy before", 64'(busy), 64'd1);
    Signal = FN_ADD;
    @(negedge clk);
    check("abort busy drop", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    check("abort no done", 64'(done_cnt - done_base), 64'd0);
    read_hilo("abort keep", 32'h0000_0001, 32'h2345_6780);

    // 6: reset while parked in WAIT
    do_start(32'd9, 32'd9);
    repeat (33) @(negedge clk);
    check("wait hold busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("wait rst busy", 64'(busy), 64'd0);
    read_hilo("wait rst", 32'h0, 32'h0);
    full_run("2x2", 32'd2, 32'd2, 32'h0, 32'h0000_0004);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
